arcade_input_cond: RTL
======================

Name: arcade_input_cond

Overview:
- Player-input conditioner between the joystick source mux (USB/DB9/DB15 merged words) and the game core's active-low button inputs.
- Synchronises the asynchronous joystick bits into the core clock domain, debounces them, and shapes coin presses into fixed-width pulses with release lockout.
- Drives Coin, Start1/2 and Fire1/2 of the bomber core and keeps a saturating credit-insert counter for the OSD/LED.

Parameters:
- DEB_CYCLES, 12000, consecutive differing samples required before a debounced bit changes (1 ms at 12 MHz); minimum 1.
- COIN_PULSE, 600000, width in clk_sys cycles of the active-low coin pulse (50 ms); minimum 1.
- AUTOFIRE_HALF, 60000, half-period in cycles of autofire toggling (optional feature only).

Ports:
- clk_sys  in  1  core clock (12 MHz).
- reset  in  1  synchronous, active-high reset.
- joy0  in  8  player-1 word, async: [7]=coin [6]=start2 [5]=start1 [4]=fire, [3:0] unused.
- joy1  in  8  player-2 word, async, same layout.
- coin_n  out  1  active-low coin pulse to core.
- start1_n  out  1  active-low debounced start 1.
- start2_n  out  1  active-low debounced start 2.
- fire1_n  out  1  active-low fire, player 1.
- fire2_n  out  1  active-low fire, player 2.
- coin_count  out  8  coins accepted since reset; saturates at 255.
- autofire_en  in  1  present only when ARCADE_INPUT_AUTOFIRE_EN is defined.

Behaviour:
- Reset (synchronous, active-high):
  - All _n outputs = 1; coin_count = 0.
  - Synchroniser flops, debounced states and counters = 0; coin FSM = IDLE.
- Source bits:
  - coin_raw = joy0[7] | joy1[7]
  - start1_raw = joy0[5]
  - start2_raw = joy0[6]
  - fire1_raw = joy0[4]
  - fire2_raw = joy1[4]
- Synchronisation: each raw bit goes through a 2-flop synchroniser, giving 2 cycles latency.
- Debounce (independent per bit, five instances):
  - Counter clears whenever sync == db.
  - While sync != db, the counter increments each cycle.
  - On the cycle the counter reaches DEB_CYCLES-1 and sync still differs, db <= sync and the counter clears.
  - Total raw-to-db latency = 2 + DEB_CYCLES cycles.
  - Any sample that equals db restarts the count, so glitches shorter than DEB_CYCLES never propagate.
- start1_n = ~start1_db, start2_n = ~start2_db, fire1_n = ~fire1_db, fire2_n = ~fire2_db. These are registered outputs: the output changes on the same edge db changes.
- Coin FSM (states IDLE, PULSE, WAIT_REL):
  - IDLE: on coin_db rising (previous 0, current 1), go to PULSE. The pulse counter loads COIN_PULSE-1, coin_n <= 0, and coin_count increments unless it is already 255.
  - PULSE: coin_n = 0 while the counter decrements. When the counter = 0, coin_n <= 1 and the FSM goes to WAIT_REL. coin_n is low for exactly COIN_PULSE cycles.
  - WAIT_REL: stay until coin_db == 0, then go to IDLE.
  - A coin held beyond the pulse produces no further pulses.
  - A second rising edge during PULSE is impossible by construction: db cannot fall and rise within less than 2*DEB_CYCLES cycles, and the FSM does not sample edges outside IDLE.
  - Coin on both players simultaneously gives one pulse, because the sources are OR'd before the synchroniser.
- Reset during PULSE: coin_n returns to 1 the cycle after reset is sampled; no pulse completion is owed.
- Start and fire bits are level signals and are not edge-shaped.

Optional Feature:
- Macro ARCADE_INPUT_AUTOFIRE_EN.
- Defined: the autofire_en port exists and a 2-flop synchroniser samples it.
  - While synced autofire_en = 1 and fireN_db = 1, fireN_n asserts (0) on the first cycle, then toggles every AUTOFIRE_HALF cycles.
  - The two players use independent phase counters, each reset when its fire_db falls.
  - When fire_db = 0 or autofire is off, fireN_n = ~fireN_db.
- Undefined: no port, no phase counters, fireN_n = ~fireN_db.

Test Plan:
- Reset only, with DEB_CYCLES=4, COIN_PULSE=10 for all tests -> all _n outputs = 1, coin_count = 0 on the first cycle after reset.
- joy0[5] held high from cycle 0 -> start1_n falls at cycle 6 (2 sync + 4 debounce). 3-cycle glitch on joy0[4] -> fire1_n stays 1.
- joy1[7] held 40 cycles -> coin_n low for exactly 10 cycles, a single pulse, coin_count = 1. Release then re-press -> second pulse, coin_count = 2.
- joy0[7] and joy1[7] rise in the same cycle -> one pulse, coin_count increments by 1.
- 256 separate coin presses -> coin_count stays 255. Reset asserted mid-PULSE -> coin_n = 1 next cycle, coin_count = 0.
- With ARCADE_INPUT_AUTOFIRE_EN, AUTOFIRE_HALF=3, autofire_en=1, fire held -> fire1_n pattern 0,0,0,1,1,1,0,… from the debounce point. With autofire_en=0 -> steady 0.

Source files
------------

// File: rtl/arcade_input_cond.sv
// arcade_input_cond: sync, debounce and coin pulse shaping of joystick words.
// Define ARCADE_INPUT_AUTOFIRE_EN to add the autofire_en port and fire toggling.
module arcade_input_cond #(
  parameter int DEB_CYCLES = 12000,
  parameter int COIN_PULSE = 600000
`ifdef ARCADE_INPUT_AUTOFIRE_EN
  ,parameter int AUTOFIRE_HALF = 60000
`endif
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic [7:0] joy0,
  input  logic [7:0] joy1,
`ifdef ARCADE_INPUT_AUTOFIRE_EN
  input  logic       autofire_en,
`endif
  output logic       coin_n,
  output logic       start1_n,
  output logic       start2_n,
  output logic       fire1_n,
  output logic       fire2_n,
  output logic [7:0] coin_count
);

  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int PW = (COIN_PULSE > 1) ? $clog2(COIN_PULSE) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [PW-1:0] PULSE_LAST = PW'(COIN_PULSE - 1);

  // bit order: 0 coin, 1 start1, 2 start2, 3 fire1, 4 fire2
  logic [4:0] raw;
  assign raw = {joy1[4], joy0[4], joy0[6], joy0[5], joy0[7] | joy1[7]};

  logic unused_joy;
  assign unused_joy = ^{joy0[3:0], joy1[6:5], joy1[3:0]};

  logic [4:0] sync1_q;
  logic [4:0] sync2_q;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  logic [4:0]    db_q;
  logic [4:0]    db_d;
  logic [DW-1:0] dcnt_q [5];
  logic [DW-1:0] dcnt_d [5];

  always_comb begin
    db_d = db_q;
    for (int i = 0; i < 5; i++) begin
      dcnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (dcnt_q[i] == DEB_LAST) db_d[i] = sync2_q[i];
        else dcnt_d[i] = dcnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      db_q <= '0;
      for (int i = 0; i < 5; i++) dcnt_q[i] <= '0;
    end else begin
      db_q <= db_d;
      for (int i = 0; i < 5; i++) dcnt_q[i] <= dcnt_d[i];
    end
  end

  typedef enum logic [1:0] {IDLE, PULSE, WAIT_REL} coin_st_e;

  coin_st_e      st_q;
  logic          coin_prev_q;
  logic          coin_n_q;
  logic [PW-1:0] pcnt_q;
  logic [7:0]    cnt_q;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      st_q        <= IDLE;
      coin_prev_q <= 1'b0;
      coin_n_q    <= 1'b1;
      pcnt_q      <= '0;
      cnt_q       <= '0;
    end else begin
      coin_prev_q <= db_q[0];
      unique case (st_q)
        IDLE: begin
          if (db_q[0] && !coin_prev_q) begin
            st_q     <= PULSE;
            pcnt_q   <= PULSE_LAST;
            coin_n_q <= 1'b0;
            if (cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
          end
        end
        PULSE: begin
          if (pcnt_q == '0) begin
            coin_n_q <= 1'b1;
            st_q     <= WAIT_REL;
          end else begin
            pcnt_q <= pcnt_q - 1'b1;
          end
        end
        WAIT_REL: begin
          if (!db_q[0]) st_q <= IDLE;
        end
        default: st_q <= IDLE;
      endcase
    end
  end

  assign coin_n     = coin_n_q;
  assign coin_count = cnt_q;
  assign start1_n   = ~db_q[1];
  assign start2_n   = ~db_q[2];

`ifdef ARCADE_INPUT_AUTOFIRE_EN
  localparam int AW = (AUTOFIRE_HALF > 1) ? $clog2(AUTOFIRE_HALF) : 1;
  localparam logic [AW-1:0] AF_LAST = AW'(AUTOFIRE_HALF - 1);

  logic          af1_q;
  logic          af2_q;
  logic [1:0]    ph_q;
  logic [AW-1:0] acnt_q [2];

  // phase 0 means "pressed"; counters rest at 0 while fire is released
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      af1_q     <= 1'b0;
      af2_q     <= 1'b0;
      ph_q      <= '0;
      acnt_q[0] <= '0;
      acnt_q[1] <= '0;
    end else begin
      af1_q <= autofire_en;
      af2_q <= af1_q;
      for (int p = 0; p < 2; p++) begin
        if (!db_q[3+p] || !af2_q) begin
          ph_q[p]   <= 1'b0;
          acnt_q[p] <= '0;
        end else if (acnt_q[p] == AF_LAST) begin
          ph_q[p]   <= ~ph_q[p];
          acnt_q[p] <= '0;
        end else begin
          acnt_q[p] <= acnt_q[p] + 1'b1;
        end
      end
    end
  end

  assign fire1_n = (af2_q && db_q[3]) ? ph_q[0] : ~db_q[3];
  assign fire2_n = (af2_q && db_q[4]) ? ph_q[1] : ~db_q[4];
`else
  assign fire1_n = ~db_q[3];
  assign fire2_n = ~db_q[4];
`endif

endmodule
